// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: shared definitions for the multiply/divide unit.
// Holds the FSM state encoding, the default datapath widths and the
// R-type funct codes the control unit decodes to raise mult_start/div_start.
package mult_div_unit_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 6;

    // R-type funct field values for mult and div.
    localparam logic [5:0] FUNCT_MULT = 6'b011000;
    localparam logic [5:0] FUNCT_DIV  = 6'b011010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/mult_div_unit_div_core.sv
// div_core: restoring-division iteration datapath (unsigned magnitudes).
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   load          - latch dividend/divisor magnitudes, clear remainder/counter
//   step          - perform one shift/trial-subtract/select iteration
//   dividend_mag  - |dividend| as an unsigned DATA_W value (2^(DATA_W-1) exact)
//   divisor_mag   - |divisor| held in DATA_W+1 bits
//   quo, rem      - current quotient / remainder magnitudes
//   last          - high while the iteration being performed is the final one
module div_core #(
    parameter int DATA_W = mult_div_unit_pkg::DATA_W,
    parameter int CNT_W  = mult_div_unit_pkg::CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] dividend_mag,
    input  logic [DATA_W:0]   divisor_mag,
    output logic [DATA_W-1:0] quo,
    output logic [DATA_W-1:0] rem,
    output logic              last
);

    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W:0]   dsr_q, dsr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W:0]   shifted;
    logic              take;

    always_comb begin
        quo_d   = quo_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        // Shift the next dividend bit into the partial remainder.
        shifted = {rem_q, quo_q[DATA_W-1]};
        // Trial subtraction succeeds when the difference would be non-negative.
        take    = (shifted >= dsr_q);
        if (load) begin
            quo_d = dividend_mag;
            rem_d = '0;
            dsr_d = divisor_mag;
            cnt_d = '0;
        end else if (step) begin
            // A kept remainder is always below the divisor, so DATA_W bits suffice.
            rem_d = take ? DATA_W'(shifted - dsr_q) : shifted[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], take};
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dsr_q <= dsr_d;
            cnt_q <= cnt_d;
        end
    end

    assign quo  = quo_q;
    assign rem  = rem_q;
    assign last = (cnt_q == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential signed multiply (radix-2 Booth) and signed
// divide (restoring, via div_core) producing the HI/LO registers.
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   a_in, b_in            - operands from the A/B registers
//   mult_start, div_start - one-cycle operation requests
//   busy                  - operation in progress
//   done                  - one-cycle completion (or divide-by-zero) pulse
//   div_zero              - one-cycle pulse with done when the divisor is zero
//   hi_out, lo_out        - HI/LO result registers
//
// Handshake: a start pulse is accepted only on an edge where busy=0
// (mult_start wins if both are high); the operands are sampled on that edge
// only. Starts seen while busy=1 are dropped. Completion is signalled by a
// single-cycle done, after which busy is already low and a new start may be
// presented in the same cycle done is visible.
module mult_div_unit #(
    parameter int DATA_W = mult_div_unit_pkg::DATA_W,
    parameter int CNT_W  = mult_div_unit_pkg::CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              mult_start,
    input  logic              div_start,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    import mult_div_unit_pkg::*;

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // Booth registers: acc and M carry an extra sign bit so acc-M cannot
    // overflow when M is the most negative value.
    logic [DATA_W:0]   acc_q, acc_d;
    logic [DATA_W:0]   m_q, m_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic              qm1_q, qm1_d;
    logic              a_neg_q, a_neg_d;
    logic              q_neg_q, q_neg_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              done_q, done_d;
    logic              dz_q, dz_d;

    logic [DATA_W:0]   booth_sum;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W:0]   b_mag;
    logic              div_load;
    logic              div_step;
    logic [DATA_W-1:0] div_quo;
    logic [DATA_W-1:0] div_rem;
    logic              div_last;

    // Unsigned magnitudes; negating the most negative value yields its exact
    // unsigned magnitude.
    assign a_mag = a_in[DATA_W-1] ? (~a_in + 1'b1) : a_in;
    assign b_mag = {1'b0, (b_in[DATA_W-1] ? (~b_in + 1'b1) : b_in)};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        m_d       = m_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        a_neg_d   = a_neg_q;
        q_neg_d   = q_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dz_d      = 1'b0;
        div_load  = 1'b0;
        div_step  = 1'b0;
        booth_sum = acc_q;

        case (state_q)
            IDLE: begin
                if (mult_start) begin
                    acc_d   = '0;
                    q_d     = b_in;
                    qm1_d   = 1'b0;
                    m_d     = {a_in[DATA_W-1], a_in};
                    cnt_d   = '0;
                    state_d = MULT;
                end else if (div_start) begin
                    if (b_in != '0) begin
                        div_load = 1'b1;
                        a_neg_d  = a_in[DATA_W-1];
                        q_neg_d  = a_in[DATA_W-1] ^ b_in[DATA_W-1];
                        state_d  = DIV;
                    end else begin
                        done_d = 1'b1;
                        dz_d   = 1'b1;
                    end
                end
            end

            MULT: begin
                case ({q_q[0], qm1_q})
                    2'b01:   booth_sum = acc_q + m_q;
                    2'b10:   booth_sum = acc_q - m_q;
                    default: booth_sum = acc_q;
                endcase
                // Arithmetic right shift of {acc, Q, Q-1}.
                acc_d = {booth_sum[DATA_W], booth_sum[DATA_W:1]};
                q_d   = {booth_sum[0], q_q[DATA_W-1:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    hi_d    = acc_d[DATA_W-1:0];
                    lo_d    = q_d;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            DIV: begin
                div_step = 1'b1;
                if (div_last) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                // Truncating division: quotient sign from the operand signs,
                // remainder sign from the dividend.
                lo_d    = q_neg_q ? (~div_quo + 1'b1) : div_quo;
                hi_d    = a_neg_q ? (~div_rem + 1'b1) : div_rem;
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            m_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            a_neg_q <= 1'b0;
            q_neg_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            a_neg_q <= a_neg_d;
            q_neg_q <= q_neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    div_core #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_div_core (
        .clock        (clock),
        .reset        (reset),
        .load         (div_load),
        .step         (div_step),
        .dividend_mag (a_mag),
        .divisor_mag  (b_mag),
        .quo          (div_quo),
        .rem          (div_rem),
        .last         (div_last)
    );

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a vector table of known results,
// a block of model-checked random operations, and hand-written sequences
// for busy collisions and reset in the middle of a divide.
module tb_mult_div_unit;

    import mult_div_unit_pkg::*;

    localparam int W = 32;

    // op: 0 = mult, 1 = div, 2 = both starts together (multiply expected)
    typedef struct {
        int         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           collide;
    } vec_t;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         mult_start;
    logic         div_start;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;

    int n_checks = 0;
    int n_pass   = 0;

    logic [2*W:0] exp_q[$];  // {div_zero, hi, lo}
    logic [W-1:0] model_hi;
    logic [W-1:0] model_lo;

    vec_t vecs[14];

    mult_div_unit dut (
        .clock      (clock),
        .reset      (reset),
        .a_in       (a_in),
        .b_in       (b_in),
        .mult_start (mult_start),
        .div_start  (div_start),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2*W:0] model(input int op, input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [W-1:0] cur_hi,
                                           input logic [W-1:0] cur_lo);
        longint la;
        longint lb;
        longint p;
        longint q;
        longint r;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        if (op != 1) begin
            p = la * lb;
            return {1'b0, p[63:32], p[31:0]};
        end
        if (b == '0) begin
            return {1'b1, cur_hi, cur_lo};
        end
        q = la / lb;
        r = la % lb;
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    // ---------------- driver ----------------
    // Pulses the start(s), scrambles the operand inputs while the unit is busy,
    // then compares latency, busy duration and the popped expected result.
    task automatic run_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int collide);
        logic [2*W:0] exp;
        int lat;
        int busy_cnt;
        int exp_lat;
        bit is_dz;
        is_dz   = (op == 1) && (b == '0);
        exp_lat = is_dz ? 0 : ((op == 1) ? 33 : 32);
        a_in       = a;
        b_in       = b;
        mult_start = (op != 1);
        div_start  = (op != 0);
        @(posedge clock); #1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            a_in      = $urandom;
            b_in      = $urandom;
            div_start = (lat == collide);
            @(posedge clock); #1;
            lat++;
        end
        div_start = 1'b0;
        check("done_latency", 64'(lat), 64'(exp_lat));
        check("busy_cycles", 64'(busy_cnt), 64'(exp_lat));
        check("busy_at_done", 64'(busy), 64'd0);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            exp = exp_q.pop_front();
            check("hi_out", 64'(hi_out), 64'(exp[2*W-1:W]));
            check("lo_out", 64'(lo_out), 64'(exp[W-1:0]));
            check("div_zero", 64'(div_zero), 64'(exp[2*W]));
        end
        @(posedge clock); #1;
        check("done_drop", 64'({done, div_zero}), 64'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [2*W:0] e;
        int op;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs[0]  = '{0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, -1};
        vecs[1]  = '{0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, -1};
        vecs[2]  = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, -1};
        vecs[3]  = '{1, 32'd17,       32'd5,        32'd2,        32'd3,        1'b0, -1};
        vecs[4]  = '{1, 32'hFFFFFFEF, 32'd5,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, -1};
        vecs[5]  = '{1, 32'd17,       32'hFFFFFFFB, 32'd2,        32'hFFFFFFFD, 1'b0, -1};
        vecs[6]  = '{1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, -1};
        vecs[7]  = '{0, 32'h66,       32'h2AAAAAAB, 32'h11,       32'h22,       1'b0, -1};
        vecs[8]  = '{1, 32'd9,        32'd0,        32'h11,       32'h22,       1'b1, -1};
        vecs[9]  = '{0, 32'd1000,     32'hFFFFFC18, 32'hFFFFFFFF, 32'hFFF0BDC0, 1'b0, 10};
        vecs[10] = '{2, 32'd100,      32'd7,        32'd0,        32'h2BC,      1'b0, -1};
        vecs[11] = '{1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        1'b0, -1};
        vecs[12] = '{0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, -1};
        vecs[13] = '{1, 32'h80000000, 32'h80000000, 32'h00000000, 32'h00000001, 1'b0, -1};

        reset      = 1'b1;
        a_in       = '0;
        b_in       = '0;
        mult_start = 1'b0;
        div_start  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'({done, div_zero}), 64'd0);
        check("reset_hi", 64'(hi_out), 64'd0);
        check("reset_lo", 64'(lo_out), 64'd0);
        reset    = 1'b0;
        model_hi = '0;
        model_lo = '0;
        @(posedge clock); #1;

        // Vector table with known results.
        for (int i = 0; i < 14; i++) begin
            exp_q.push_back({vecs[i].dz, vecs[i].hi, vecs[i].lo});
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].collide);
            model_hi = vecs[i].hi;
            model_lo = vecs[i].lo;
        end

        // Random operations checked against the arithmetic model.
        for (int i = 0; i < 12; i++) begin
            op = int'($urandom_range(0, 1));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
            e  = model(op, ra, rb, model_hi, model_lo);
            exp_q.push_back(e);
            run_op(op, ra, rb, -1);
            model_hi = e[2*W-1:W];
            model_lo = e[W-1:0];
        end

        // Make sure HI/LO are non-zero so the reset clearing is observable.
        exp_q.push_back(model(0, 32'd5, 32'd9, model_hi, model_lo));
        run_op(0, 32'd5, 32'd9, -1);

        // Reset at cycle 15 of a divide.
        a_in      = 32'hFFFFFF9C;
        b_in      = 32'd7;
        div_start = 1'b1;
        @(posedge clock); #1;
        div_start = 1'b0;
        repeat (14) begin
            @(posedge clock); #1;
        end
        check("busy_mid_div", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'({done, div_zero}), 64'd0);
        check("rst_mid_hi", 64'(hi_out), 64'd0);
        check("rst_mid_lo", 64'(lo_out), 64'd0);
        check("rst_mid_state", 64'(dut.state_q), 64'(IDLE));
        begin
            int seen_done;
            seen_done = 0;
            repeat (40) begin
                @(posedge clock); #1;
                if (done || busy) seen_done++;
            end
            check("no_activity_after_reset", 64'(seen_done), 64'd0);
        end
        model_hi = '0;
        model_lo = '0;
        exp_q.push_back({1'b0, 32'd0, 32'd42});
        run_op(0, 32'd6, 32'd7, -1);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
